avl_mtimer: RTL

AVL_MTIMER -- requirements
Module: avl_mtimer

---
 rtl/mtimer_pkg.sv | 31 +++
 rtl/avl_mtimer_if.sv | 22 ++
 rtl/mtimer_prescaler.sv | 23 ++
 rtl/avl_mtimer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared register map, CTRL field positions, FSM encoding and byte-lane merge helper
// for the Avalon machine timer.
package mtimer_pkg;

    localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFF_CTRL        = 8'h10;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_PS_LSB = 8;
    localparam int CTRL_PS_MSB = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/avl_mtimer_if.sv
// Avalon-MM slave bus bundle for the machine timer; master drives requests, slave answers.
interface avl_mtimer_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic                  read;
    logic                  write;
    logic [31:0]           readdata;
    logic                  waitrequest;

    modport master (
        output address, writedata, byteenable, read, write,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, read, write,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mtimer_prescaler.sv
// Tick divider: one tick every prescale+1 cycles; clear restarts the count and
// suppresses the tick in its own cycle.
module mtimer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] prescale,
    output logic       tick
);
    logic [7:0] count;

    assign tick = !clear && (count == prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end
endmodule

// File: rtl/avl_mtimer.sv
// Avalon-MM machine timer (mtime/mtimecmp/CTRL); reads take one wait state, writes none.
// Define MTIMER_SNAPSHOT_EN to return an MTIME_HI shadow latched by MTIME_LO reads.
module avl_mtimer
    import mtimer_pkg::*;
#(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    avl_mtimer_if.slave  bus,
    output logic         timer_irq
);
    state_t                state, state_nxt;
    logic [63:0]           mtime, mtimecmp;
    logic                  en;
    logic [7:0]            prescale;
    logic                  tick;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic                  sel_lo, sel_hi, sel_clo, sel_chi, sel_ctrl;
    logic                  rd_acc;
    logic [31:0]           rd_mux, ctrl_rd, hi_rd, readdata;

    assign addr_word = bus.address & ~ADDR_WIDTH'(3);
    assign sel_lo    = (addr_word == ADDR_WIDTH'(OFF_MTIME_LO));
    assign sel_hi    = (addr_word == ADDR_WIDTH'(OFF_MTIME_HI));
    assign sel_clo   = (addr_word == ADDR_WIDTH'(OFF_MTIMECMP_LO));
    assign sel_chi   = (addr_word == ADDR_WIDTH'(OFF_MTIMECMP_HI));
    assign sel_ctrl  = (addr_word == ADDR_WIDTH'(OFF_CTRL));

    // A simultaneous write wins: the read half is dropped and never stalls.
    assign rd_acc          = (state == ST_IDLE) && bus.read && !bus.write;
    assign bus.waitrequest = rd_acc && !reset;
    assign bus.readdata    = readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: if (rd_acc) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    mtimer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (bus.write && sel_ctrl),
        .prescale (prescale),
        .tick     (tick)
    );

    // Software writes to either mtime word take priority over the tick increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (bus.write && sel_lo) begin
            mtime[31:0] <= byte_merge(mtime[31:0], bus.writedata, bus.byteenable);
        end else if (bus.write && sel_hi) begin
            mtime[63:32] <= byte_merge(mtime[63:32], bus.writedata, bus.byteenable);
        end else if (en && tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtimecmp <= CMP_RESET;
            en       <= 1'b1;
            prescale <= '0;
        end else if (bus.write) begin
            if (sel_clo) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], bus.writedata, bus.byteenable);
            if (sel_chi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], bus.writedata, bus.byteenable);
            if (sel_ctrl && bus.byteenable[0]) en       <= bus.writedata[CTRL_EN_BIT];
            if (sel_ctrl && bus.byteenable[1]) prescale <= bus.writedata[CTRL_PS_MSB:CTRL_PS_LSB];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_irq <= 1'b0;
        else       timer_irq <= (mtime >= mtimecmp);
    end

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                mtime_hi_shadow <= '0;
        else if (rd_acc && sel_lo) mtime_hi_shadow <= mtime[63:32];
    end
    assign hi_rd = mtime_hi_shadow;
`else
    assign hi_rd = mtime[63:32];
`endif

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN_BIT]             = en;
        ctrl_rd[CTRL_PS_MSB:CTRL_PS_LSB] = prescale;
    end

    always_comb begin
        rd_mux = '0;
        if (sel_lo)   rd_mux = mtime[31:0];
        if (sel_hi)   rd_mux = hi_rd;
        if (sel_clo)  rd_mux = mtimecmp[31:0];
        if (sel_chi)  rd_mux = mtimecmp[63:32];
        if (sel_ctrl) rd_mux = ctrl_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       readdata <= '0;
        else if (rd_acc) readdata <= rd_mux;
    end
endmodule
